// File: rtl/gelato_pkg.sv
// Shared types and constants for the gelato merge/scheduling blocks.
// Other files reach this package through import gelato_pkg::*.
package gelato_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int NUM_PORTS_MAX = 32;
  localparam int SRC_IDX_W     = 5;

  // Wide enough to name any legal source channel.
  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter_if.sv
// Handshake bundle between the upstream FIFO bank, the round-robin merge and its consumer.
// master = environment side, slave = arbiter side; in_last exists only with GELATO_ARB_LOCK_EN.
interface gelato_rr_arbiter_if
  import gelato_pkg::*;
#(
  parameter int  NUM_PORTS = NUM_PORTS_DEF,
  parameter type T         = logic
);
  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0] in_valid;
  T                     in_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_ready;
`ifdef GELATO_ARB_LOCK_EN
  logic [NUM_PORTS-1:0] in_last;
`endif
  logic                 out_valid;
  T                     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
`ifdef GELATO_ARB_LOCK_EN
    output in_last,
`endif
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef GELATO_ARB_LOCK_EN
    input  in_last,
`endif
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/gelato_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Double-width search: low half is req masked to indices >= ptr, high half is raw req.
module gelato_rr_pick
  import gelato_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  localparam int IDX_W    = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 any_o
);

  logic [NUM_PORTS-1:0]   mask;
  logic [2*NUM_PORTS-1:0] dbl;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
  end

  assign dbl = {req_i, req_i & mask};

  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && dbl[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && dbl[NUM_PORTS+j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/gelato_rr_arbiter.sv
// N-to-1 round-robin merge into a single registered output slot, full throughput.
// Optional packet lock (holds the grant until in_last) is enabled by GELATO_ARB_LOCK_EN.
module gelato_rr_arbiter
  import gelato_pkg::*;
#(
  parameter int  NUM_PORTS = NUM_PORTS_DEF,
  parameter type T         = logic
) (
  input logic                clk,
  input logic                rst_n,
  gelato_rr_arbiter_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 any;
  logic                 load_en;
  logic                 xfer;
  T                     pick_data;

  logic                 out_valid_q, out_valid_d;
  T                     out_data_q,  out_data_d;
  logic [IDX_W-1:0]     out_idx_q,   out_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]     ptr_after;

`ifdef GELATO_ARB_LOCK_EN
  logic                 lock_q, lock_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
  logic                 pick_last;

  // While a packet is open, only its owner may compete, valid or not.
  always_comb begin
    req = bus.in_valid;
    if (lock_q) req = bus.in_valid & (NUM_PORTS'(1) << lock_idx_q);
  end

  assign pick_last = |(bus.in_last & gnt);
`else
  assign req = bus.in_valid;
`endif

  gelato_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  assign load_en      = !out_valid_q || bus.out_ready;
  assign xfer         = load_en && any;
  assign bus.in_ready = (rst_n && load_en) ? gnt : '0;
  assign ptr_after    = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) pick_data = bus.in_data[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef GELATO_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_data;
      out_idx_d   = gnt_idx;
`ifdef GELATO_ARB_LOCK_EN
      if (pick_last) begin
        rr_ptr_d = ptr_after;
        lock_d   = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
`else
      rr_ptr_d    = ptr_after;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef GELATO_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef GELATO_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_gelato_rr_arbiter.sv
// Self-checking bench for gelato_rr_arbiter: vector tables, hand sequences and a
// randomized run against a modulo-search reference model (4-, 3- and 1-port instances).
module tb_gelato_rr_arbiter;
  import gelato_pkg::*;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gelato_rr_arbiter_if #(.NUM_PORTS(4), .T(byte_t)) bus4 ();
  gelato_rr_arbiter_if #(.NUM_PORTS(3), .T(byte_t)) bus3 ();
  gelato_rr_arbiter_if #(.NUM_PORTS(1), .T(byte_t)) bus1 ();

  gelato_rr_arbiter #(.NUM_PORTS(4), .T(byte_t)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  gelato_rr_arbiter #(.NUM_PORTS(3), .T(byte_t)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  gelato_rr_arbiter #(.NUM_PORTS(1), .T(byte_t)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [3:0] v;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] idx;
    byte_t      dat;
  } vec_t;

  vec_t  tbl[$];
  vec_t  lck[$];
  int    checks   = 0;
  int    failures = 0;

  // reference model state for the 4-port randomized run
  int    m_ptr;
  bit    m_ov;
  byte_t m_od;
  int    m_oi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [3:0] v, input logic [3:0] last, input logic ordy);
    bus4.in_valid  = v;
    bus4.out_ready = ordy;
`ifdef GELATO_ARB_LOCK_EN
    bus4.in_last   = last;
`else
    if (last === 4'bx) $display("note: in_last unknown");
`endif
  endtask

  task automatic run_row(input string tag, input vec_t r);
    drive4(r.v, r.last, r.ordy);
    #1;
    chk({tag, "_in_ready"}, 32'(bus4.in_ready), 32'(r.rdy));
    tick();
    chk({tag, "_out_valid"}, 32'(bus4.out_valid), 32'(r.ov));
    chk({tag, "_out_idx"}, 32'(bus4.out_idx), 32'(r.idx));
    chk({tag, "_out_data"}, 32'(bus4.out_data), 32'(r.dat));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector tables ----------------
    for (int k = 0; k < 11; k++)
      tbl.push_back('{4'hF, 4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 8'(8'h10 + k % 4)});
    tbl.push_back('{4'b1100, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13});
    tbl.push_back('{4'b1100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});
    tbl.push_back('{4'b1100, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13});
    tbl.push_back('{4'b0110, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
    tbl.push_back('{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11});
    tbl.push_back('{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11});
    tbl.push_back('{4'b1111, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});
    tbl.push_back('{4'b1111, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12});
    tbl.push_back('{4'b1111, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13});

    // packet lock: ch0 single beat, then ch1 3-beat packet with a gap, then 2, 0
    lck.push_back('{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10});
    lck.push_back('{4'b0111, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
    lck.push_back('{4'b0111, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
    lck.push_back('{4'b0101, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11});
    lck.push_back('{4'b0111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
    lck.push_back('{4'b0111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});
    lck.push_back('{4'b0111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10});

    // ---------------- reset with all inputs valid ----------------
    rst_n = 1'b0;
    drive4(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) bus4.in_data[i] = 8'(8'h10 + i);
    bus3.in_valid = '0; bus3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) bus3.in_data[i] = 8'(8'h30 + i);
    bus1.in_valid = '0; bus1.out_ready = 1'b1; bus1.in_data[0] = 8'h00;
`ifdef GELATO_ARB_LOCK_EN
    bus3.in_last = '1;
    bus1.in_last = '1;
`endif
    repeat (2) tick();
    chk("rst_in_ready", 32'(bus4.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("rst_out_idx", 32'(bus4.out_idx), 32'h0);
    chk("rst_out_data", 32'(bus4.out_data), 32'h0);
    rst_n = 1'b1;

    // ---------------- table: rotation, ch2/ch3, idle hold, stall ----------------
    foreach (tbl[k]) run_row($sformatf("tbl%0d", k), tbl[k]);

    // ---------------- backpressure on 0xA5 from ch1 ----------------
    bus4.in_data[1] = 8'hA5;
    run_row("bp_load", '{4'b0010, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA5});
    bus4.in_data[1] = 8'h5A;
    for (int k = 0; k < 3; k++)
      run_row($sformatf("bp_stall%0d", k), '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA5});
    run_row("bp_release", '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});

    // ---------------- reset mid-transfer drops the output item ----------------
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("midrst_in_ready", 32'(bus4.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;

    // ---------------- randomized run vs reference model ----------------
    m_ptr = 0; m_ov = 1'b0; m_od = 8'h00; m_oi = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] v;
      logic       ordy;
      byte_t      d [4];
      int         g;
      v    = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        d[i] = 8'($urandom);
        bus4.in_data[i] = d[i];
      end
      drive4(v, 4'hF, ordy);
      g = -1;
      if (!m_ov || ordy) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
      end
      #1;
      chk("rnd_in_ready", 32'(bus4.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      tick();
      if (g >= 0) begin
        m_ov = 1'b1; m_od = d[g]; m_oi = g; m_ptr = (g + 1) % 4;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      chk("rnd_out_valid", 32'(bus4.out_valid), 32'(m_ov));
      chk("rnd_out_idx", 32'(bus4.out_idx), 32'(m_oi));
      chk("rnd_out_data", 32'(bus4.out_data), 32'(m_od));
    end
    drive4(4'h0, 4'hF, 1'b1);

    // ---------------- 3 ports: wrap 2 -> 0 ----------------
    bus3.in_valid = 3'b111;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("p3_in_ready", 32'(bus3.in_ready), 32'd1 << (k % 3));
      tick();
      chk("p3_out_idx", 32'(bus3.out_idx), 32'(k % 3));
      chk("p3_out_data", 32'(bus3.out_data), 32'(8'h30 + k % 3));
    end
    bus3.in_valid = '0;

    // ---------------- 1 port: always ch0 ----------------
    begin
      bit ov1;
      ov1 = 1'b0;
      for (int k = 0; k < 40; k++) begin
        logic v1, r1;
        v1 = 1'($urandom);
        r1 = 1'($urandom);
        bus1.in_valid  = v1;
        bus1.out_ready = r1;
        bus1.in_data[0] = 8'(k);
        #1;
        chk("p1_in_ready", 32'(bus1.in_ready), 32'(v1 && (!ov1 || r1)));
        tick();
        if (v1 && (!ov1 || r1)) ov1 = 1'b1;
        else if (r1) ov1 = 1'b0;
        chk("p1_out_valid", 32'(bus1.out_valid), 32'(ov1));
        chk("p1_out_idx", 32'(bus1.out_idx), 32'h0);
      end
      bus1.in_valid = '0;
    end

`ifdef GELATO_ARB_LOCK_EN
    // ---------------- packet lock ----------------
    pulse_reset();
    for (int i = 0; i < 4; i++) bus4.in_data[i] = 8'(8'h10 + i);
    foreach (lck[k]) run_row($sformatf("lock%0d", k), lck[k]);
`else
    pulse_reset();
    chk("final_rst_out_valid", 32'(bus4.out_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gelato_rr_arbiter.md
Name: gelato_rr_arbiter

Overview:
N-to-1 round-robin merge stage. It sits directly downstream of a bank of gelato_fifo instances (one per warp or requester) and consumes their dout/dout_valid/dout_ready streams. One winner per cycle is forwarded into a single registered output slot feeding a shared unit (e.g. the memory request port). Full throughput; fair rotation among requesters.

Parameters:
- NUM_PORTS, 4, number of input channels; legal range 1..32.
- T, logic, payload type, identical to the upstream FIFO element type.
- IDX_W (localparam), max(1, $clog2(NUM_PORTS)), width of the source index.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, [NUM_PORTS], per-channel valid; driven by FIFO dout_valid.
- in_data, input, T [NUM_PORTS], per-channel payload.
- in_ready, output, [NUM_PORTS], per-channel ready; drives FIFO dout_ready.
- out_valid, output, 1, output slot holds data.
- out_data, output, T, registered payload.
- out_idx, output, IDX_W, channel the payload came from.
- out_ready, input, 1, downstream accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data='0, out_idx=0, rr_ptr=0, lock state cleared. in_ready is forced to all-zero while rst_n=0.
- load_en = !out_valid || out_ready. The output slot is a one-entry pipeline register.
- Arbitration: when load_en=1, search in_valid cyclically from rr_ptr upward. The first valid index is g.
- in_ready[g]=1 only when load_en=1 and g is the winner. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid of any channel and on out_ready.
  - in_valid must not depend on in_ready.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - Next cycle: out_valid=1, out_data=in_data[g], out_idx=g.
  - rr_ptr is set to g+1. If g+1 equals NUM_PORTS, rr_ptr wraps to 0 (correct for non-power-of-2 NUM_PORTS).
- Output transfer with no new winner: out_valid falls to 0 next cycle. out_data and out_idx hold their last values.
- Stall (out_valid=1, out_ready=0): out_data and out_idx hold, all in_ready=0, rr_ptr holds.
- Simultaneous output transfer and new winner: back-to-back, one item per cycle, no bubble.
- Latency: input transfer to out_valid is 1 cycle.
- No valid input: rr_ptr is unchanged. Grant priority is never changed without a transfer.
- NUM_PORTS=1: always grant 0; out_idx is 0.
- Fairness: with all channels continuously valid and out_ready=1, channels are served in order rr_ptr, rr_ptr+1, ..., each once per NUM_PORTS cycles.
- Reset asserted mid-transfer: the in-flight output item is dropped and nothing is replayed. Upstream FIFOs are reset by the same rst_n.

Optional Feature:
- Macro: GELATO_ARB_LOCK_EN (packet lock).
- Defined:
  - Adds port in_last, input, [NUM_PORTS]; marks the final beat of a multi-beat packet.
  - A transfer with in_last[g]=0 sets lock on g.
  - While locked, only channel g is eligible. Other channels get in_ready=0 even if g is not valid.
  - rr_ptr advances to g+1 only on the beat where in_last[g]=1, which also clears the lock.
  - Reset clears the lock.
- Undefined: the in_last port is absent and every beat re-arbitrates.

Decomposition:
- Shared package gelato_pkg: typedef of the source-index type and the NUM_PORTS default constant for the memory request merge.
- One combinational sub-module, gelato_rr_pick.
  - Inputs: req[NUM_PORTS], ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Implemented by double-width masked priority search.
  - Reused by later schedulers.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0000, out_valid=0; after release, first grant is ch0.
- NUM_PORTS=4, all valid, out_ready=1 for 8 cycles -> out_idx sequence 0,1,2,3,0,1,2,3; one item per cycle, no bubble.
- Only ch2 and ch3 valid, rr_ptr=3 -> grant 3, then 2, then 3. Afterwards, drop all valid for 2 cycles -> rr_ptr holds, out_valid falls after 1 cycle.
- Backpressure: out_ready=0 for 3 cycles with out_data=0xA5 from ch1 -> out_data/out_idx stable at 0xA5/1, in_ready=0000; out_ready=1 -> next item loads same cycle.
- NUM_PORTS=3, all valid -> out_idx 0,1,2,0 (wrap from 2 to 0, never 3).
- With GELATO_ARB_LOCK_EN: ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch2 are valid -> out_idx 1,1,1,2,0; ch0 and ch2 see in_ready=0 during the packet.
